// File: rtl/uart_loop_pkg.sv
// uart_loop_pkg: shared state encoding, default terminator and counter width helpers for the UART loopback buffer
package uart_loop_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, PULSE, WAIT_BUSY, WAIT_IDLE} state_e;
    localparam int TERM_DEFAULT = 'h0D;
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
    function automatic int tmo_w(input int tmo);
        return $clog2(tmo + 1);
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with head read and occupancy; a push into a full FIFO lands only if a pop frees a slot
module sync_fifo import uart_loop_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_W-1:0]         din,
    output logic [DATA_W-1:0]         head,
    output logic                      full,
    output logic                      empty,
    output logic [lvl_w(DEPTH)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic wr_en;
    always_comb begin
        wr_en   = push && (!full || pop);
        wr_d    = wr_q + AW'(wr_en);
        rd_d    = rd_q + AW'(pop);
        level_d = level_q + LW'(wr_en) - LW'(pop);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= din;
    end
    assign full  = level_q == LW'(DEPTH);
    assign empty = level_q == '0;
    assign head  = mem_q[rd_q];
    assign level = level_q;
endmodule

// File: rtl/uart_loop_fifo.sv
// uart_loop_fifo: buffers received UART words and feeds them to the transmitter, optionally releasing only whole lines
module uart_loop_fifo import uart_loop_pkg::*; #(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 16,
    parameter int                LINE_MODE = 0,
    parameter logic [DATA_W-1:0] TERM      = DATA_W'(TERM_DEFAULT),
    parameter int                BUSY_TMO  = 8
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      recv_done,
    input  logic [DATA_W-1:0]         recv_data,
    input  logic                      tx_busy,
    output logic                      send_en,
    output logic [DATA_W-1:0]         send_data,
    output logic [lvl_w(DEPTH)-1:0]   fifo_level,
    output logic                      overflow
);
    localparam int LW = lvl_w(DEPTH);
    localparam int TW = tmo_w(BUSY_TMO);
    state_e state_q, state_d;
    logic d0_q, d0_d, d1_q, d1_d;
    logic overflow_q, overflow_d;
    logic [DATA_W-1:0] send_data_q, send_data_d, head;
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic push, pop, push_ok, full, empty, eligible;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk(sys_clk), .rst_n(sys_rst_n), .push(push), .pop(pop), .din(recv_data),
        .head(head), .full(full), .empty(empty), .level(fifo_level)
    );

    always_comb begin
        d0_d        = recv_done;
        d1_d        = d0_q;
        push        = d0_q && !d1_q;
        pop         = state_q == LOAD;
        push_ok     = push && (!full || pop);
        overflow_d  = overflow_q || (push && !push_ok);
        line_cnt_d  = line_cnt_q + LW'(push_ok && recv_data == TERM) - LW'(pop && head == TERM);
        // a full buffer must drain even without a terminator, otherwise nothing could ever be accepted again
        eligible    = !empty && (LINE_MODE == 0 || line_cnt_q != '0 || full);
        state_d     = state_q;
        send_data_d = send_data_q;
        tmo_d       = tmo_q;
        case (state_q)
            IDLE:      if (eligible && !tx_busy) begin
                           state_d     = LOAD;
                           send_data_d = head;
                       end
            LOAD:      state_d = PULSE;
            PULSE:     begin
                           state_d = WAIT_BUSY;
                           tmo_d   = '0;
                       end
            WAIT_BUSY: if (tx_busy) state_d = WAIT_IDLE;
                       else if (tmo_q == TW'(BUSY_TMO - 1)) state_d = IDLE;
                       else tmo_d = tmo_q + TW'(1);
            WAIT_IDLE: if (!tx_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            d0_q        <= 1'b0;
            d1_q        <= 1'b0;
            overflow_q  <= 1'b0;
            send_data_q <= '0;
            line_cnt_q  <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            d0_q        <= d0_d;
            d1_q        <= d1_d;
            overflow_q  <= overflow_d;
            send_data_q <= send_data_d;
            line_cnt_q  <= line_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    assign send_en   = state_q == PULSE;
    assign send_data = send_data_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_uart_loop_fifo.sv
// tb_uart_loop_fifo: directed plus randomized checks of echo and line-mode loopback against a queue-based model
module tb_uart_loop_fifo;
    localparam int DEPTH = 16;
    localparam int BUSY_TMO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rd_a, rd_b;
    logic busy_a = 1'b0, busy_b = 1'b0;
    logic [7:0] data_a, data_b, sd_a, sd_b;
    logic en_a, en_b, ovf_a, ovf_b;
    logic [4:0] lvl_a, lvl_b;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int bmode_a = 0;
    int t_a = 100, t_b = 100;
    int unstable = 0, doubles = 0;
    logic prev_en_a = 1'b0, prev_en_b = 1'b0;
    logic [7:0] prev_a = '0, prev_b = '0;
    logic [7:0] got_a[$], got_b[$];
    int tc_a[$];

    uart_loop_fifo #(.DATA_W(8), .DEPTH(DEPTH), .LINE_MODE(0), .TERM(8'h0D), .BUSY_TMO(BUSY_TMO)) u_echo (
        .sys_clk(clk), .sys_rst_n(rst_n), .recv_done(rd_a), .recv_data(data_a), .tx_busy(busy_a),
        .send_en(en_a), .send_data(sd_a), .fifo_level(lvl_a), .overflow(ovf_a)
    );
    uart_loop_fifo #(.DATA_W(8), .DEPTH(DEPTH), .LINE_MODE(1), .TERM(8'h0D), .BUSY_TMO(BUSY_TMO)) u_line (
        .sys_clk(clk), .sys_rst_n(rst_n), .recv_done(rd_b), .recv_data(data_b), .tx_busy(busy_b),
        .send_en(en_b), .send_data(sd_b), .fifo_level(lvl_b), .overflow(ovf_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // transmitter model (busy 2..11 cycles after each start pulse) and send monitor
    always @(negedge clk) begin
        t_a = en_a ? 0 : (t_a < 100 ? t_a + 1 : t_a);
        t_b = en_b ? 0 : (t_b < 100 ? t_b + 1 : t_b);
        busy_a = bmode_a == 1 || (bmode_a == 0 && t_a >= 2 && t_a < 12);
        busy_b = t_b >= 2 && t_b < 12;
        if (en_a) begin
            got_a.push_back(sd_a);
            tc_a.push_back(cyc);
            if (sd_a !== prev_a) unstable++;
            if (prev_en_a) doubles++;
        end
        if (en_b) begin
            got_b.push_back(sd_b);
            if (sd_b !== prev_b) unstable++;
            if (prev_en_b) doubles++;
        end
        prev_en_a = en_a;
        prev_en_b = en_b;
        prev_a = sd_a;
        prev_b = sd_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    task automatic check_seq(input string tag, input logic [7:0] got[$], input logic [7:0] want[$]);
        check({tag, "_count"}, got.size(), want.size());
        for (int i = 0; i < want.size(); i++)
            check(tag, i < got.size() ? {24'h0, got[i]} : 32'hxxxxxxxx, {24'h0, want[i]});
    endtask

    task automatic push(input bit which, input logic [7:0] d, input int gap);
        @(negedge clk);
        if (which) begin data_b = d; rd_b = 1'b1; end
        else begin data_a = d; rd_a = 1'b1; end
        @(negedge clk);
        rd_a = 1'b0;
        rd_b = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_n(input bit which, input int n, input int budget);
        for (int i = 0; i < budget && (which ? got_b.size() : got_a.size()) < n; i++) @(negedge clk);
        check(which ? "pulses_line" : "pulses_echo", which ? got_b.size() : got_a.size(), n);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] v;
        int n0;
        rst_n = 1'b0;
        rd_a = 1'b0; rd_b = 1'b0; data_a = '0; data_b = '0;
        repeat (3) @(negedge clk);
        check("rst_send_en", en_a, 0);
        check("rst_send_data", sd_a, 0);
        check("rst_level", lvl_a, 0);
        check("rst_overflow", ovf_a, 0);
        check("rst_level_line", lvl_b, 0);
        check("rst_send_en_line", en_b, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // first word: exact push-to-send latency
        n0 = cyc; data_a = 8'h41; rd_a = 1'b1; exp_q.push_back(8'h41);
        @(negedge clk); check("level_pre_push", lvl_a, 0);
        @(negedge clk); check("level_post_push", lvl_a, 1); rd_a = 1'b0;
        wait_n(0, 1, 20);
        check("latency", tc_a.size() > 0 ? tc_a[0] - n0 : -1, 4);
        check("level_after_pop", lvl_a, 0);
        repeat (20) @(negedge clk);
        push(0, 8'h42, 20); exp_q.push_back(8'h42);
        push(0, 8'h43, 20); exp_q.push_back(8'h43);
        for (int i = 0; i < 10; i++) begin
            v = 8'($urandom);
            push(0, v, $urandom_range(1, 28));
            exp_q.push_back(v);
        end
        wait_n(0, exp_q.size(), 600);
        repeat (30) @(negedge clk);
        check_seq("echo_data", got_a, exp_q);
        check("echo_level_end", lvl_a, 0);
        check("echo_overflow", ovf_a, 0);

        // transmitter held busy: fill past capacity
        bmode_a = 1; got_a.delete(); exp_q.delete();
        repeat (2) @(negedge clk);
        for (int i = 0; i < DEPTH + 2; i++) begin
            push(0, 8'(i), 0);
            if (i < DEPTH) exp_q.push_back(8'(i));
        end
        repeat (3) @(negedge clk);
        check("full_level", lvl_a, DEPTH);
        check("full_overflow", ovf_a, 1);
        check("held_no_send", got_a.size(), 0);
        bmode_a = 0;
        wait_n(0, DEPTH, 800);
        repeat (30) @(negedge clk);
        check_seq("ovf_drain", got_a, exp_q);
        check("ovf_drain_level", lvl_a, 0);
        check("overflow_sticky", ovf_a, 1);

        // transmitter never answers: each send ends by timeout
        bmode_a = 2;
        repeat (15) @(negedge clk);
        got_a.delete(); tc_a.delete(); exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            v = 8'($urandom);
            push(0, v, 0);
            exp_q.push_back(v);
        end
        wait_n(0, 3, 100);
        check_seq("tmo_data", got_a, exp_q);
        check("tmo_gap1", tc_a.size() > 2 ? tc_a[1] - tc_a[0] : -1, BUSY_TMO + 3);
        check("tmo_gap2", tc_a.size() > 2 ? tc_a[2] - tc_a[1] : -1, BUSY_TMO + 3);
        repeat (20) @(negedge clk);

        // line mode: nothing leaves until the terminator arrives
        exp_q.delete();
        push(1, 8'h68, 0); push(1, 8'h69, 0);
        repeat (30) @(negedge clk);
        check("line_hold", got_b.size(), 0);
        check("line_hold_level", lvl_b, 2);
        push(1, 8'h0D, 0);
        exp_q = '{8'h68, 8'h69, 8'h0D};
        wait_n(1, 3, 200);
        repeat (20) @(negedge clk);
        check_seq("line_data", got_b, exp_q);
        check("line_level_end", lvl_b, 0);
        got_b.delete(); exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            v = 8'($urandom);
            if (v == 8'h0D) v = 8'h0E;
            push(1, v, 0);
            exp_q.push_back(v);
        end
        repeat (40) @(negedge clk);
        check("full_override_count", got_b.size(), 1);
        check("full_override_data", got_b.size() > 0 ? {24'h0, got_b[0]} : 32'hxxxxxxxx, {24'h0, exp_q[0]});
        check("full_override_level", lvl_b, DEPTH - 1);
        push(1, 8'h0D, 0);
        exp_q.push_back(8'h0D);
        wait_n(1, DEPTH + 1, 600);
        repeat (20) @(negedge clk);
        check_seq("line_drain", got_b, exp_q);
        check("line_drain_level", lvl_b, 0);
        check("line_overflow", ovf_b, 0);

        // reset while the transmitter is busy with words still queued
        bmode_a = 1; got_a.delete();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) push(0, 8'($urandom), 0);
        repeat (3) @(negedge clk);
        check("rst_mid_fill", lvl_a, 6);
        bmode_a = 0;
        wait_n(0, 1, 50);
        repeat (5) @(negedge clk);
        check("rst_mid_queued", lvl_a, 5);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_level", lvl_a, 0);
        check("rst_mid_send_en", en_a, 0);
        check("rst_mid_send_data", sd_a, 0);
        check("rst_mid_overflow", ovf_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("rst_mid_no_send", got_a.size(), 1);
        check("rst_mid_level_end", lvl_a, 0);
        check("data_stable_before_pulse", unstable, 0);
        check("single_cycle_pulse", doubles, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
